// File: rtl/i_pf_pkg.sv
// i_pf_pkg: shared widths and FSM state type for the instruction prefetch buffer
package i_pf_pkg;
  localparam int LINE_W = 128;
  localparam int LADDR_W = 28;
  typedef enum logic [1:0] {IDLE, FETCH, RESP, PREFETCH} state_t;
endpackage

// File: rtl/i_pf_entry.sv
// i_pf_entry: single prefetch line entry with hit compare and next-line address
import i_pf_pkg::*;
module i_pf_entry (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [LADDR_W-1:0] base_addr,
  input  logic [LADDR_W-1:0] lookup_addr,
  input  logic [LINE_W-1:0]  load_data,
  output logic               hit,
  output logic [LADDR_W-1:0] pf_addr,
  output logic [LINE_W-1:0]  pf_data
);
  logic pf_valid;
  assign hit = pf_valid && lookup_addr == pf_addr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pf_valid <= 1'b0;
      pf_addr  <= '0;
      pf_data  <= '0;
    end else if (clear) begin
      pf_valid <= 1'b0;
      pf_addr  <= base_addr + LADDR_W'(1);
    end else if (load) begin
      pf_valid <= 1'b1;
      pf_data  <= load_data;
    end
endmodule

// File: rtl/i_prefetch_buffer.sv
// i_prefetch_buffer: next-line instruction prefetcher between icache and memory
import i_pf_pkg::*;
module i_prefetch_buffer #(
  parameter bit PF_ENABLE = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cache_read_i,
  input  logic [LADDR_W-1:0] cache_addr_i,
  output logic [LINE_W-1:0]  cache_rdata_o,
  output logic               cache_ready_o,
  output logic               mem_read_o,
  output logic [LADDR_W-1:0] mem_addr_o,
  input  logic [LINE_W-1:0]  mem_rdata_i,
  input  logic               mem_ready_i,
  output logic [CNT_W-1:0]   demand_cnt_o,
  output logic [CNT_W-1:0]   pf_hit_cnt_o
);
  state_t state, nxt;
  logic [LADDR_W-1:0] cur_addr, pf_addr;
  logic [LINE_W-1:0] pf_data;
  logic hit_raw, hit, accept, pf_hit;
  assign hit    = PF_ENABLE && hit_raw;
  assign accept = state == IDLE && cache_read_i;
  assign pf_hit = accept && hit;
  assign cache_ready_o = state == RESP;
  assign mem_read_o    = state == FETCH || state == PREFETCH;
  assign mem_addr_o    = state == PREFETCH ? pf_addr : cur_addr;
  i_pf_entry u_entry (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (PF_ENABLE && state == RESP),
    .load       (state == PREFETCH && mem_ready_i),
    .base_addr  (cur_addr),
    .lookup_addr(cache_addr_i),
    .load_data  (mem_rdata_i),
    .hit        (hit_raw),
    .pf_addr    (pf_addr),
    .pf_data    (pf_data)
  );
  always_comb
    nxt = state == IDLE  ? (cache_read_i ? (hit ? RESP : FETCH) : IDLE) :
          state == FETCH ? (mem_ready_i ? RESP : FETCH) :
          state == RESP  ? (PF_ENABLE ? PREFETCH : IDLE) :
                           (mem_ready_i ? IDLE : PREFETCH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      cur_addr      <= '0;
      cache_rdata_o <= '0;
      demand_cnt_o  <= '0;
      pf_hit_cnt_o  <= '0;
    end else begin
      state <= nxt;
      if (accept) cur_addr <= cache_addr_i;
      if (pf_hit) cache_rdata_o <= pf_data;
      else if (state == FETCH && mem_ready_i) cache_rdata_o <= mem_rdata_i;
      if (accept && ~&demand_cnt_o) demand_cnt_o <= demand_cnt_o + CNT_W'(1);
      if (pf_hit && ~&pf_hit_cnt_o) pf_hit_cnt_o <= pf_hit_cnt_o + CNT_W'(1);
    end
endmodule
